mem_arbiter: RTL

Two-requester arbiter that shares the single byte-addressable data/instruction memory between the instruction-fetch port and the load/store port of the core. Accepts one request per grant and drives the memory's combinational-read and clocked-write port for exactly one cycle. Returns registered read data or a write acknowledge to the winning requester. Sits between the fetch/LSU stages and the `memory` instance.

---
 rtl/mem_arb_pkg.sv | 45 ++++
 rtl/mem_arb_pick.sv | 25 ++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, requester ids, the
// latched-request record, load/store size codes and the alignment check.
package mem_arb_pkg;

  // Load/store size and sign codes carried on funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  // Control part of the request captured at grant; address and store data
  // are held in separate registers because their widths are parameters.
  typedef struct packed {
    req_id_t    id;
    logic       we;
    logic [2:0] funct3;
    logic       err;
  } arb_req_t;

  // size is funct3[1:0]: halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between the fetch and load/store requests.
// With MEM_ARB_RR_EN defined, ties go to the port that did not win last;
// otherwise the data port always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_data,  // 1 = data port won the previous grant
`endif
  output logic pick_vld,
  output logic pick_data   // 1 = data port wins, 0 = fetch port wins
);

  // Combinational priority: single requester wins outright, ties by policy
  always_comb begin
    pick_vld  = i_req | d_req;
    pick_data = d_req;
`ifdef MEM_ARB_RR_EN
    if (i_req && d_req && last_data) pick_data = 1'b0;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory between instruction fetch and
// load/store. One access per grant: IDLE/RESP -> ACCESS -> RESP.
// Handshake: a requester holds req until it sees its gnt high in a cycle;
// the request is taken at the rising edge that ends that cycle, and exactly
// one rsp_vld pulse follows two cycles later (unless reset intervenes).
// Optional macro MEM_ARB_RR_EN selects round-robin tie breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_i,
  input  logic [AWIDTH-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rsp_vld_o,
  output logic [DWIDTH-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_rsp_vld_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic [1:0]        dbg_state_o
);

  arb_state_t        state, state_nxt;
  arb_req_t          cur;
  logic [AWIDTH-1:0] cur_addr;
  logic [DWIDTH-1:0] cur_wdata;
  logic [DWIDTH-1:0] rsp_data;
  logic              can_grant, take;
  logic              pick_vld, pick_data;

`ifdef MEM_ARB_RR_EN
  logic last_data;
`endif

  mem_arb_pick u_pick (
    .i_req     (i_req_i),
    .d_req     (d_req_i),
`ifdef MEM_ARB_RR_EN
    .last_data (last_data),
`endif
    .pick_vld  (pick_vld),
    .pick_data (pick_data)
  );

  // Grant and next-state: grants only from IDLE/RESP, never while in reset
  always_comb begin
    can_grant = !rst && (state == ARB_IDLE || state == ARB_RESP);
    take      = can_grant && pick_vld;
    i_gnt_o   = take && !pick_data;
    d_gnt_o   = take && pick_data;
    state_nxt = state;
    case (state)
      ARB_IDLE, ARB_RESP: state_nxt = take ? ARB_ACCESS : ARB_IDLE;
      ARB_ACCESS:         state_nxt = ARB_RESP;
      default:            state_nxt = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Latch the winning request; fetch is always an aligned-agnostic LW
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= '0;
      cur_addr  <= '0;
      cur_wdata <= '0;
    end else if (take) begin
      cur.id     <= pick_data ? REQ_DATA : REQ_FETCH;
      cur.we     <= pick_data && d_we_i;
      cur.funct3 <= pick_data ? d_funct3_i : F3_LW;
      cur.err    <= pick_data && is_misaligned(d_funct3_i[1:0], d_addr_i[1:0]);
      cur_addr   <= pick_data ? d_addr_i : i_addr_i;
      cur_wdata  <= pick_data ? d_wdata_i : '0;
    end
  end

  // Capture read data at the end of ACCESS; stores and faults return 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     rsp_data <= '0;
    else if (state == ARB_ACCESS) rsp_data <= (cur.we || cur.err) ? '0 : mem_data_i;
  end

`ifdef MEM_ARB_RR_EN
  // Last-winner register; reset value "fetch last" lets data win first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_data <= 1'b0;
    else if (take) last_data <= pick_data;
  end
`endif

  // Memory port and response outputs, all zero outside their state
  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_funct3_o   = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    i_rsp_vld_o    = 1'b0;
    i_rdata_o      = '0;
    d_rsp_vld_o    = 1'b0;
    d_rdata_o      = '0;
    d_err_o        = 1'b0;
    dbg_state_o    = state;
    if (state == ARB_ACCESS) begin
      mem_addr_o     = cur_addr;
      mem_data_o     = cur_wdata;
      mem_funct3_o   = cur.funct3;
      mem_read_en_o  = !cur.we && !cur.err;
      mem_write_en_o = cur.we && !cur.err;
    end
    if (state == ARB_RESP) begin
      if (cur.id == REQ_DATA) begin
        d_rsp_vld_o = 1'b1;
        d_rdata_o   = rsp_data;
        d_err_o     = cur.err;
      end else begin
        i_rsp_vld_o = 1'b1;
        i_rdata_o   = rsp_data;
      end
    end
  end

endmodule
